// File: rtl/shadow_ram_pkg.sv
// Shared encodings for the shadow RAM loader: SPI opcodes, lock keys and default widths.
package shadow_ram_pkg;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    OP_SET_ADDR_LO = 2'd0,
    OP_SET_ADDR_HI = 2'd1,
    OP_WRITE_DATA  = 2'd2,
    OP_LOCK_CTL    = 2'd3
  } spi_op_e;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  localparam logic [7:0] LOCK_KEY   = 8'hA5;
  localparam logic [7:0] UNLOCK_KEY = 8'h5A;

endpackage

// File: rtl/shadow_ram_arbiter.sv
// Arbitrates shadow RAM writes between the Z80 (absolute priority, never stalled)
// and an SPI loader with an address pointer, saturating byte count and lock control.
module shadow_ram_arbiter
  import shadow_ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              z80_req,
  input  logic [ADDR_W-1:0] z80_addr,
  input  logic [DATA_W-1:0] z80_data,
  input  logic              spi_cmd_valid,
  input  logic [1:0]        spi_cmd,
  input  logic [7:0]        spi_byte,
  output logic              spi_cmd_ready,
  output logic [ADDR_W-1:0] ram_addr_w,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_write_en,
  output logic              locked,
  output logic [ADDR_W-1:0] load_ptr,
  output logic [ADDR_W:0]   load_count,
  output logic              err_sticky
);

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  lock_state_e       r_state;
  lock_state_e       w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_err;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;

  spi_op_e w_op;
  logic    w_spi_acc;
  logic    w_spi_wr;
  logic    w_spi_err;
  logic    w_unlock;

  // SPI only gets a slot when the Z80 is idle; nothing is accepted during reset.
  assign spi_cmd_ready = ~z80_req & ~rst;
  assign w_op          = spi_op_e'(spi_cmd);
  assign w_spi_acc     = spi_cmd_valid & spi_cmd_ready;
  assign w_spi_wr      = w_spi_acc && (w_op == OP_WRITE_DATA) && (r_state == ST_UNLOCKED);
  assign w_spi_err     = w_spi_acc && (w_op == OP_WRITE_DATA) && (r_state == ST_LOCKED);
  assign w_unlock      = w_spi_acc && (w_op == OP_LOCK_CTL) && (spi_byte == UNLOCK_KEY);

  always_comb begin
    w_state_nxt = r_state;
    if (w_spi_acc && (w_op == OP_LOCK_CTL)) begin
      if (spi_byte == LOCK_KEY)
        w_state_nxt = ST_LOCKED;
      else if (spi_byte == UNLOCK_KEY)
        w_state_nxt = ST_UNLOCKED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_UNLOCKED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write port: one write per cycle, Z80 first; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
    end else begin
      r_wr_en <= z80_req | w_spi_wr;
      if (z80_req) begin
        r_addr <= z80_addr;
        r_din  <= z80_data;
      end else if (w_spi_wr) begin
        r_addr <= r_ptr;
        r_din  <= DATA_W'(spi_byte);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_spi_acc) begin
      case (w_op)
        OP_SET_ADDR_LO: r_ptr[7:0]        <= spi_byte;
        OP_SET_ADDR_HI: r_ptr[ADDR_W-1:8] <= spi_byte[ADDR_W-9:0];
        OP_WRITE_DATA:  if (r_state == ST_UNLOCKED) r_ptr <= r_ptr + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_unlock)
        r_count <= '0;
      else if (w_spi_wr && (r_count != CNT_MAX))
        r_count <= r_count + 1'b1;
      if (w_unlock)
        r_err <= 1'b0;
      else if (w_spi_err)
        r_err <= 1'b1;
    end
  end

  assign ram_write_en = r_wr_en;
  assign ram_addr_w   = r_addr;
  assign ram_din      = r_din;
  assign locked       = (r_state == ST_LOCKED);
  assign load_ptr     = r_ptr;
  assign load_count   = r_count;
  assign err_sticky   = r_err;

endmodule

// File: tb/tb_shadow_ram_arbiter.sv
// Directed bench for shadow_ram_arbiter: load, collision, wrap, lock, back-to-back, reset.
module tb_shadow_ram_arbiter;
  import shadow_ram_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        z80_req;
  logic [13:0] z80_addr;
  logic [7:0]  z80_data;
  logic        spi_cmd_valid;
  logic [1:0]  spi_cmd;
  logic [7:0]  spi_byte;
  logic        spi_cmd_ready;
  logic [13:0] ram_addr_w;
  logic [7:0]  ram_din;
  logic        ram_write_en;
  logic        locked;
  logic [13:0] load_ptr;
  logic [14:0] load_count;
  logic        err_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  shadow_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .z80_req(z80_req), .z80_addr(z80_addr), .z80_data(z80_data),
    .spi_cmd_valid(spi_cmd_valid), .spi_cmd(spi_cmd), .spi_byte(spi_byte),
    .spi_cmd_ready(spi_cmd_ready),
    .ram_addr_w(ram_addr_w), .ram_din(ram_din), .ram_write_en(ram_write_en),
    .locked(locked), .load_ptr(load_ptr), .load_count(load_count),
    .err_sticky(err_sticky)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] b);
    spi_cmd_valid = 1'b1; spi_cmd = op; spi_byte = b;
    step();
    spi_cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; z80_req = 1'b0; z80_addr = '0; z80_data = '0;
    spi_cmd_valid = 1'b1; spi_cmd = OP_WRITE_DATA; spi_byte = 8'hEE;
    step(); step();
    n_tests++; if (spi_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b exp 0", spi_cmd_ready); end
    n_tests++; if (ram_write_en !== 1'b0) begin n_fail++; $display("FAIL rst_wen: got %b exp 0", ram_write_en); end
    n_tests++; if (ram_addr_w !== 14'h0 || ram_din !== 8'h0) begin n_fail++; $display("FAIL rst_addr_din: got %h/%h exp 0/0", ram_addr_w, ram_din); end
    n_tests++; if (locked !== 1'b0 || err_sticky !== 1'b0) begin n_fail++; $display("FAIL rst_lock_err: got %b/%b exp 0/0", locked, err_sticky); end
    n_tests++; if (load_ptr !== 14'h0 || load_count !== 15'h0) begin n_fail++; $display("FAIL rst_ptr_cnt: got %h/%h exp 0/0", load_ptr, load_count); end
    spi_cmd_valid = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_load();
    send(OP_LOCK_CTL, 8'h5A);
    send(OP_SET_ADDR_LO, 8'h00);
    n_tests++; if (ram_write_en !== 1'b0) begin n_fail++; $display("FAIL load_setaddr_nowrite: got %b exp 0", ram_write_en); end
    send(OP_SET_ADDR_HI, 8'h04);
    n_tests++; if (load_ptr !== 14'h0400) begin n_fail++; $display("FAIL load_setptr: got %h exp 0400", load_ptr); end
    send(OP_WRITE_DATA, 8'h11);
    n_tests++; if (ram_write_en !== 1'b1 || ram_addr_w !== 14'h0400 || ram_din !== 8'h11) begin n_fail++; $display("FAIL load_wr0: got %b %h %h exp 1 0400 11", ram_write_en, ram_addr_w, ram_din); end
    send(OP_WRITE_DATA, 8'h22);
    n_tests++; if (ram_write_en !== 1'b1 || ram_addr_w !== 14'h0401 || ram_din !== 8'h22) begin n_fail++; $display("FAIL load_wr1: got %b %h %h exp 1 0401 22", ram_write_en, ram_addr_w, ram_din); end
    n_tests++; if (load_ptr !== 14'h0402 || load_count !== 15'd2) begin n_fail++; $display("FAIL load_ptr_cnt: got %h %0d exp 0402 2", load_ptr, load_count); end
    step();
    n_tests++; if (ram_write_en !== 1'b0 || ram_addr_w !== 14'h0401 || ram_din !== 8'h22) begin n_fail++; $display("FAIL load_idle_hold: got %b %h %h exp 0 0401 22", ram_write_en, ram_addr_w, ram_din); end
  endtask

  task automatic test_collision();
    send(OP_SET_ADDR_LO, 8'h10);
    send(OP_SET_ADDR_HI, 8'h00);
    z80_req = 1'b1; z80_addr = 14'h2000; z80_data = 8'h77;
    spi_cmd_valid = 1'b1; spi_cmd = OP_WRITE_DATA; spi_byte = 8'h55;
    #1;
    n_tests++; if (spi_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL coll_ready_n: got %b exp 0", spi_cmd_ready); end
    step();
    z80_req = 1'b0;
    #1;
    n_tests++; if (ram_write_en !== 1'b1 || ram_addr_w !== 14'h2000 || ram_din !== 8'h77) begin n_fail++; $display("FAIL coll_z80_wr: got %b %h %h exp 1 2000 77", ram_write_en, ram_addr_w, ram_din); end
    n_tests++; if (spi_cmd_ready !== 1'b1 || load_ptr !== 14'h0010) begin n_fail++; $display("FAIL coll_pending: got ready %b ptr %h exp 1 0010", spi_cmd_ready, load_ptr); end
    step();
    spi_cmd_valid = 1'b0;
    n_tests++; if (ram_write_en !== 1'b1 || ram_addr_w !== 14'h0010 || ram_din !== 8'h55) begin n_fail++; $display("FAIL coll_spi_wr: got %b %h %h exp 1 0010 55", ram_write_en, ram_addr_w, ram_din); end
    n_tests++; if (load_ptr !== 14'h0011 || load_count !== 15'd3) begin n_fail++; $display("FAIL coll_ptr_cnt: got %h %0d exp 0011 3", load_ptr, load_count); end
  endtask

  task automatic test_wrap();
    send(OP_SET_ADDR_LO, 8'hFF);
    send(OP_SET_ADDR_HI, 8'h3F);
    n_tests++; if (load_ptr !== 14'h3FFF) begin n_fail++; $display("FAIL wrap_setptr: got %h exp 3fff", load_ptr); end
    send(OP_WRITE_DATA, 8'hAB);
    n_tests++; if (ram_write_en !== 1'b1 || ram_addr_w !== 14'h3FFF || ram_din !== 8'hAB) begin n_fail++; $display("FAIL wrap_wr: got %b %h %h exp 1 3fff ab", ram_write_en, ram_addr_w, ram_din); end
    n_tests++; if (load_ptr !== 14'h0000 || load_count !== 15'd4) begin n_fail++; $display("FAIL wrap_ptr: got %h %0d exp 0000 4", load_ptr, load_count); end
  endtask

  task automatic test_lock();
    send(OP_SET_ADDR_LO, 8'h34);
    send(OP_SET_ADDR_HI, 8'h12);
    send(OP_LOCK_CTL, 8'hA5);
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_enter: got %b exp 1", locked); end
    send(OP_WRITE_DATA, 8'h99);
    n_tests++; if (ram_write_en !== 1'b0 || err_sticky !== 1'b1) begin n_fail++; $display("FAIL lock_blocked: got wen %b err %b exp 0 1", ram_write_en, err_sticky); end
    n_tests++; if (load_ptr !== 14'h1234 || load_count !== 15'd4) begin n_fail++; $display("FAIL lock_ptr_hold: got %h %0d exp 1234 4", load_ptr, load_count); end
    send(OP_LOCK_CTL, 8'h00);
    n_tests++; if (locked !== 1'b1 || err_sticky !== 1'b1) begin n_fail++; $display("FAIL lock_noop_key: got %b %b exp 1 1", locked, err_sticky); end
    z80_req = 1'b1; z80_addr = 14'h0123; z80_data = 8'h3C;
    step();
    z80_req = 1'b0;
    n_tests++; if (ram_write_en !== 1'b1 || ram_addr_w !== 14'h0123 || ram_din !== 8'h3C) begin n_fail++; $display("FAIL lock_z80_wr: got %b %h %h exp 1 0123 3c", ram_write_en, ram_addr_w, ram_din); end
    send(OP_LOCK_CTL, 8'h5A);
    n_tests++; if (locked !== 1'b0 || err_sticky !== 1'b0 || load_count !== 15'd0) begin n_fail++; $display("FAIL lock_exit: got %b %b %0d exp 0 0 0", locked, err_sticky, load_count); end
  endtask

  task automatic test_back_to_back();
    logic [13:0] exp_a;
    spi_cmd_valid = 1'b1; spi_cmd = OP_WRITE_DATA; spi_byte = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      z80_req = 1'b1; z80_addr = 14'h0100 + 14'(i); z80_data = 8'(i + 1);
      #1;
      n_tests++; if (spi_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_%0d: got %b exp 0", i, spi_cmd_ready); end
      step();
      exp_a = 14'h0100 + 14'(i);
      n_tests++; if (ram_write_en !== 1'b1 || ram_addr_w !== exp_a || ram_din !== 8'(i + 1)) begin n_fail++; $display("FAIL b2b_wr_%0d: got %b %h %h exp 1 %h %h", i, ram_write_en, ram_addr_w, ram_din, exp_a, 8'(i + 1)); end
    end
    z80_req = 1'b0;
    #1;
    n_tests++; if (spi_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after: got %b exp 1", spi_cmd_ready); end
    step();
    spi_cmd_valid = 1'b0;
    n_tests++; if (ram_write_en !== 1'b1 || ram_addr_w !== 14'h1234 || ram_din !== 8'hC3) begin n_fail++; $display("FAIL b2b_spi_wr: got %b %h %h exp 1 1234 c3", ram_write_en, ram_addr_w, ram_din); end
    n_tests++; if (load_ptr !== 14'h1235 || load_count !== 15'd1) begin n_fail++; $display("FAIL b2b_ptr_cnt: got %h %0d exp 1235 1", load_ptr, load_count); end
  endtask

  task automatic test_reset_mid();
    send(OP_SET_ADDR_LO, 8'h77);
    spi_cmd_valid = 1'b1; spi_cmd = OP_WRITE_DATA; spi_byte = 8'h5E;
    step();
    rst = 1'b1; z80_req = 1'b1; z80_addr = 14'h0abc; z80_data = 8'h42;
    #1;
    n_tests++; if (spi_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready: got %b exp 0", spi_cmd_ready); end
    step();
    n_tests++; if (ram_write_en !== 1'b0 || ram_addr_w !== 14'h0 || ram_din !== 8'h0) begin n_fail++; $display("FAIL rmid_wr: got %b %h %h exp 0 0 0", ram_write_en, ram_addr_w, ram_din); end
    n_tests++; if (load_ptr !== 14'h0 || load_count !== 15'h0 || locked !== 1'b0 || err_sticky !== 1'b0) begin n_fail++; $display("FAIL rmid_state: got %h %0d %b %b exp 0 0 0 0", load_ptr, load_count, locked, err_sticky); end
    rst = 1'b0; z80_req = 1'b0; spi_cmd_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_load();
    test_collision();
    test_wrap();
    test_lock();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shadow_ram_arbiter.md
SHADOW_RAM_ARBITER -- requirements
Module: shadow_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, shadow RAM write-address width.
REQ-002 Parameter DATA_W, default 8, shadow RAM data width.
REQ-003 Port clk  in  1  single clock for all logic.
REQ-004 Port rst  in  1  reset, synchronous to clk and active-high.
REQ-005 Port z80_req  in  1  one-cycle pulse requesting a Z80 write to the shadow RAM; it cannot be stalled.
REQ-006 Port z80_addr  in  ADDR_W  Z80 write address, valid with z80_req.
REQ-007 Port z80_data  in  DATA_W  Z80 write data, valid with z80_req.
REQ-008 Port spi_cmd_valid  in  1  SPI host command present.
REQ-009 Port spi_cmd  in  2  opcode: 0=SET_ADDR_LO, 1=SET_ADDR_HI, 2=WRITE_DATA, 3=LOCK_CTL.
REQ-010 Port spi_byte  in  8  command operand.
REQ-011 Port spi_cmd_ready  out  1  command accepted this cycle when high together with spi_cmd_valid.
REQ-012 Port ram_addr_w  out  ADDR_W  block RAM write address.
REQ-013 Port ram_din  out  DATA_W  block RAM write data.
REQ-014 Port ram_write_en  out  1  block RAM write strobe.
REQ-015 Port locked  out  1  high when SPI loading is locked.
REQ-016 Port load_ptr  out  ADDR_W  current SPI load address.
REQ-017 Port load_count  out  ADDR_W+1  saturating count of SPI bytes written since the last unlock.
REQ-018 Port err_sticky  out  1  set when a WRITE_DATA command arrives while locked.

Function
REQ-019 Z80 requests SHALL have absolute priority: spi_cmd_ready = ~z80_req (combinational), so a Z80 write is never dropped.
REQ-020 A Z80 request in cycle N SHALL produce ram_write_en=1 in cycle N+1, with ram_addr_w=z80_addr and ram_din=z80_data registered from cycle N.
REQ-021 An accepted SET_ADDR_LO SHALL load load_ptr[7:0] from spi_byte; SET_ADDR_HI SHALL load load_ptr[ADDR_W-1:8] from spi_byte[ADDR_W-9:0]; neither SHALL write RAM.
REQ-022 An accepted WRITE_DATA while unlocked SHALL write spi_byte to load_ptr in cycle N+1 (same latency as Z80), then increment load_ptr modulo 2^ADDR_W (0x3FFF wraps to 0x0000) and increment load_count, saturating at 2^ADDR_W.
REQ-023 An accepted WRITE_DATA while locked SHALL be consumed without writing RAM or changing load_ptr, and SHALL set err_sticky.
REQ-024 The lock FSM SHALL have two states, UNLOCKED and LOCKED: LOCK_CTL with 0xA5 moves to LOCKED; LOCK_CTL with 0x5A moves to UNLOCKED and clears load_count and err_sticky; any other LOCK_CTL operand is a no-op.
REQ-025 When no write is granted, ram_write_en SHALL be 0 in the next cycle; ram_addr_w and ram_din SHALL hold their last values.
REQ-026 At most one RAM write SHALL be issued per cycle; an SPI command presented during z80_req SHALL stay pending (not accepted) and be accepted in the first cycle without z80_req.
REQ-027 Z80 writes SHALL be honoured in both lock states.

Reset
REQ-028 While rst=1: state UNLOCKED, locked=0, load_ptr=0, load_count=0, err_sticky=0, ram_write_en=0, ram_addr_w=0, ram_din=0.
REQ-029 Reset asserted mid-operation SHALL suppress any write scheduled for the next cycle (ram_write_en=0 after the reset edge).
REQ-030 spi_cmd_ready SHALL be 0 while rst=1.

Structure
REQ-031 Opcode encodings, the lock keys 0xA5/0x5A, and the default ADDR_W SHALL live in a shared package, shadow_ram_pkg.
REQ-032 The block SHALL be a single module with no sub-modules; the block_ram instance stays outside, driven by this block's write port.

Verification
REQ-033 Load: unlock, SET_ADDR_LO 0x00, SET_ADDR_HI 0x04, WRITE_DATA 0x11,0x22 -> writes 0x11@0x0400 and 0x22@0x0401; load_ptr=0x0402, load_count=2.
REQ-034 Collision: z80_req (addr 0x2000, data 0x77) in the same cycle as a valid WRITE_DATA 0x55 at ptr 0x0010 -> cycle N+1 writes 0x77@0x2000, SPI accepted at N+1, cycle N+2 writes 0x55@0x0010.
REQ-035 Wrap: ptr 0x3FFF, WRITE_DATA 0xAB -> write@0x3FFF, load_ptr=0x0000.
REQ-036 Lock: LOCK_CTL 0xA5, then WRITE_DATA 0x99 -> no RAM write, err_sticky=1, load_ptr unchanged; LOCK_CTL 0x5A -> locked=0, err_sticky=0, load_count=0.
REQ-037 Reset mid-write: accept WRITE_DATA, assert rst in the next cycle -> ram_write_en=0 and all outputs at their reset values.
REQ-038 Z80 back-to-back: z80_req for 3 consecutive cycles -> 3 consecutive writes, spi_cmd_ready low for those 3 cycles.
